// File: rtl/data_mem_responder_if.sv
// Load/store port bundle between the LSU (master) and the data memory responder (slave).
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_fn3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_fn3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_fn3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: byte/half/word loads and stores with lane merging,
// load extension and error flagging; one outstanding response.
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    localparam int unsigned IDX_W = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;

    localparam logic [2:0] FN_B  = 3'b000;
    localparam logic [2:0] FN_H  = 3'b001;
    localparam logic [2:0] FN_W  = 3'b010;
    localparam logic [2:0] FN_BU = 3'b100;
    localparam logic [2:0] FN_HU = 3'b101;

    typedef enum logic {IDLE, RESP} state_t;

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic        err;
    logic [3:0]  byte_en;
    logic [31:0] wdata_rep;
    logic [IDX_W-1:0] idx;

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_word;
    logic        r_error;
    logic        r_load;
    logic [1:0]  r_lane;
    logic [2:0]  r_fn3;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] rdata_ext;

    assign idx           = bus.req_addr[ADDR_WIDTH-1:2];
    assign bus.req_ready = (state == IDLE) || bus.resp_ready;
    assign accept        = bus.req_valid && bus.req_ready;

    // Decode legality, byte enables and lane-replicated store data.
    always_comb begin
        err       = 1'b0;
        byte_en   = 4'b0000;
        wdata_rep = bus.req_wdata;
        case (bus.req_fn3)
            FN_B, FN_BU: begin
                byte_en   = 4'(4'b0001 << bus.req_addr[1:0]);
                wdata_rep = {4{bus.req_wdata[7:0]}};
                if (bus.req_write && (bus.req_fn3 == FN_BU)) err = 1'b1;
            end
            FN_H, FN_HU: begin
                byte_en   = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{bus.req_wdata[15:0]}};
                if (bus.req_addr[0]) err = 1'b1;
                if (bus.req_write && (bus.req_fn3 == FN_HU)) err = 1'b1;
            end
            FN_W: begin
                byte_en   = 4'b1111;
                wdata_rep = bus.req_wdata;
                if (bus.req_addr[1:0] != 2'b00) err = 1'b1;
            end
            default: err = 1'b1;
        endcase
        if (|bus.req_addr[31:ADDR_WIDTH]) err = 1'b1;
    end

    // Memory array: merged store commit and synchronous read on acceptance; never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (bus.req_write && !err) begin
                for (int i = 0; i < 4; i++) begin
                    if (byte_en[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
            rd_word <= mem[idx];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // FSM next state: any accept lands in RESP; a stalled response holds RESP.
    always_comb begin
        next_state = IDLE;
        if (accept)                                 next_state = RESP;
        else if (state == RESP && !bus.resp_ready)  next_state = RESP;
    end

    // Response attributes captured alongside the read word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_error <= 1'b0;
            r_load  <= 1'b0;
            r_lane  <= 2'b00;
            r_fn3   <= 3'b000;
        end else if (accept) begin
            r_error <= err;
            r_load  <= !bus.req_write && !err;
            r_lane  <= bus.req_addr[1:0];
            r_fn3   <= bus.req_fn3;
        end
    end

    // Lane select and sign/zero extension from the registered word.
    always_comb begin
        lane_byte = rd_word[{r_lane, 3'b000} +: 8];
        lane_half = r_lane[1] ? rd_word[31:16] : rd_word[15:0];
        rdata_ext = rd_word;
        case (r_fn3)
            FN_B:    rdata_ext = {{24{lane_byte[7]}}, lane_byte};
            FN_H:    rdata_ext = {{16{lane_half[15]}}, lane_half};
            FN_BU:   rdata_ext = {24'd0, lane_byte};
            FN_HU:   rdata_ext = {16'd0, lane_half};
            default: rdata_ext = rd_word;
        endcase
        if (!r_load) rdata_ext = 32'd0;
    end

    assign bus.resp_valid = (state == RESP);
    assign bus.resp_error = r_error;
    assign bus.resp_rdata = rdata_ext;
endmodule
